arbiter_dest: RTL and testbench

ARBITER_DEST -- requirements
Module: arbiter_dest

---
 rtl/arb_dest_pkg.sv | 14 +
 rtl/dest_fifo.sv | 77 +++++++
 rtl/arbiter_dest.sv | 139 +++++++++++++
 tb/tb_arbiter_dest.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_dest_pkg.sv
// Shared FSM encoding and sizing constants for the VC-to-destination arbiter.
package arb_dest_pkg;

  localparam int unsigned Depth    = 4;
  localparam int unsigned CntWidth = 5;

  typedef enum logic [1:0] {
    StReset,
    StInit,
    StIdle,
    StActive
  } arb_state_e;

endpackage

// File: rtl/dest_fifo.sv
// Destination FIFO with registered read data, threshold-based almost-full and a sticky error flag.
// Optional accepted-push counter when ARB_COUNT_EN is defined.
module dest_fifo
  import arb_dest_pkg::*;
#(
  parameter int unsigned data_width    = 6,
  parameter int unsigned address_width = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  input  logic [2:0]            thr,
  output logic [data_width-1:0] data_out,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  error,
  output logic [CntWidth-1:0]   cnt
);

  localparam int unsigned FifoDepth = 1 << address_width;
  localparam int unsigned CntW      = address_width + 1;

  logic [data_width-1:0]    mem_q [FifoDepth];
  logic [address_width-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]          count_q;
  logic [data_width-1:0]    data_q;
  logic                     error_q;
  logic                     full, push_ok, pop_ok;

  assign full        = (count_q == CntW'(FifoDepth));
  assign empty       = (count_q == '0);
  // Threshold of 0 keeps almost_full asserted; flag is forced low while in reset.
  assign almost_full = ~reset & (32'(count_q) >= 32'(thr));
  assign pop_ok      = pop & ~empty;
  assign push_ok     = push & (~full | pop);
  assign data_out    = data_q;
  assign error       = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + address_width'(1);
      if (pop_ok) begin
        rptr_q <= rptr_q + address_width'(1);
        data_q <= mem_q[rptr_q];
      end
      if (push_ok && !pop_ok) count_q <= count_q + CntW'(1);
      if (pop_ok && !push_ok) count_q <= count_q - CntW'(1);
      if ((push && !push_ok) || (pop && !pop_ok)) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

`ifdef ARB_COUNT_EN
  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)        cnt_q <= '0;
    else if (push_ok) cnt_q <= cnt_q + CntWidth'(1);
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/arbiter_dest.sv
// Strict-priority arbiter draining two VC FIFOs into two destination FIFOs routed by word MSB.
// Define ARB_COUNT_EN to enable the per-destination accepted-word counters.
module arbiter_dest
  import arb_dest_pkg::*;
#(
  parameter int unsigned data_width    = 6,
  parameter int unsigned address_width = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [2:0]            Umbral_D0,
  input  logic [2:0]            Umbral_D1,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  pop_D0,
  input  logic                  pop_D1,
  output logic                  pop_VC0_fifo,
  output logic                  pop_VC1_fifo,
  output logic [data_width-1:0] data_out_D0,
  output logic [data_width-1:0] data_out_D1,
  output logic                  empty_D0,
  output logic                  empty_D1,
  output logic                  almost_full_D0,
  output logic                  almost_full_D1,
  output logic                  error_D0,
  output logic                  error_D1,
  output logic                  active_out,
  output logic                  idle_out,
  output logic [CntWidth-1:0]   cnt_D0,
  output logic [CntWidth-1:0]   cnt_D1
);

  arb_state_e            state_q;
  logic                  idle_q, active_q, valid_q, sel_q;
  logic [2:0]            thr0_q, thr1_q;
  logic                  pause, run, busy, push_d0, push_d1;
  logic [data_width-1:0] word;

  assign pause        = almost_full_D0 | almost_full_D1;
  assign run          = ~reset & ~pause & ((state_q == StIdle) | (state_q == StActive));
  assign pop_VC0_fifo = run & ~empty_fifo_VC0;
  assign pop_VC1_fifo = run & ~empty_fifo_VC1 & ~pop_VC0_fifo;

  // Upstream read data arrives the cycle after the pop, selected by the registered source.
  assign word    = sel_q ? data_out_VC1 : data_out_VC0;
  assign push_d0 = valid_q & ~word[data_width-1];
  assign push_d1 = valid_q & word[data_width-1];
  assign busy    = ~empty_fifo_VC0 | ~empty_fifo_VC1 | ~empty_D0 | ~empty_D1 | valid_q;

  assign idle_out   = idle_q;
  assign active_out = active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StReset;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      thr0_q   <= '0;
      thr1_q   <= '0;
    end else begin
      valid_q  <= pop_VC0_fifo | pop_VC1_fifo;
      sel_q    <= pop_VC1_fifo;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      unique case (state_q)
        StReset: state_q <= StInit;
        StInit: begin
          thr0_q <= Umbral_D0;
          thr1_q <= Umbral_D1;
          if (!init) begin
            state_q <= StIdle;
            idle_q  <= 1'b1;
          end
        end
        StIdle: begin
          if (init) begin
            state_q <= StInit;
          end else if (busy) begin
            state_q  <= StActive;
            active_q <= 1'b1;
          end else begin
            idle_q <= 1'b1;
          end
        end
        StActive: begin
          if (init) begin
            state_q <= StInit;
          end else if (!busy) begin
            state_q <= StIdle;
            idle_q  <= 1'b1;
          end else begin
            active_q <= 1'b1;
          end
        end
        default: state_q <= StReset;
      endcase
    end
  end

  dest_fifo #(
    .data_width    (data_width),
    .address_width (address_width)
  ) u_fifo_d0 (
    .clk         (clk),
    .reset       (reset),
    .push        (push_d0),
    .push_data   (word),
    .pop         (pop_D0),
    .thr         (thr0_q),
    .data_out    (data_out_D0),
    .empty       (empty_D0),
    .almost_full (almost_full_D0),
    .error       (error_D0),
    .cnt         (cnt_D0)
  );

  dest_fifo #(
    .data_width    (data_width),
    .address_width (address_width)
  ) u_fifo_d1 (
    .clk         (clk),
    .reset       (reset),
    .push        (push_d1),
    .push_data   (word),
    .pop         (pop_D1),
    .thr         (thr1_q),
    .data_out    (data_out_D1),
    .empty       (empty_D1),
    .almost_full (almost_full_D1),
    .error       (error_D1),
    .cnt         (cnt_D1)
  );

endmodule

// File: tb/tb_arbiter_dest.sv
// Self-checking bench for arbiter_dest: queue-based reference model, directed and random stimulus.
module tb_arbiter_dest;
  import arb_dest_pkg::*;

  localparam int W = 6;
  localparam int MReset = 0, MInit = 1, MIdle = 2, MActive = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1, init = 1'b0;
  logic [2:0]   Umbral_D0 = '0, Umbral_D1 = '0;
  logic         empty_fifo_VC0 = 1'b1, empty_fifo_VC1 = 1'b1;
  logic [W-1:0] data_out_VC0 = '0, data_out_VC1 = '0;
  logic         pop_D0 = 1'b0, pop_D1 = 1'b0;
  logic         pop_VC0_fifo, pop_VC1_fifo;
  logic [W-1:0] data_out_D0, data_out_D1;
  logic         empty_D0, empty_D1, almost_full_D0, almost_full_D1, error_D0, error_D1;
  logic         active_out, idle_out;
  logic [4:0]   cnt_D0, cnt_D1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] vc0q[$], vc1q[$];
  logic [W-1:0] dq[2][$];
  logic [W-1:0] vc0_word = '0, vc1_word = '0;
  logic [W-1:0] m_dout[2];
  int           m_thr[2], m_cnt[2];
  bit           m_err[2];
  bit           m_pend = 0, m_src = 0;
  int           m_st = MReset;

  always #5 clk = ~clk;

  arbiter_dest #(
    .data_width    (W),
    .address_width (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .Umbral_D0      (Umbral_D0),
    .Umbral_D1      (Umbral_D1),
    .empty_fifo_VC0 (empty_fifo_VC0),
    .empty_fifo_VC1 (empty_fifo_VC1),
    .data_out_VC0   (data_out_VC0),
    .data_out_VC1   (data_out_VC1),
    .pop_D0         (pop_D0),
    .pop_D1         (pop_D1),
    .pop_VC0_fifo   (pop_VC0_fifo),
    .pop_VC1_fifo   (pop_VC1_fifo),
    .data_out_D0    (data_out_D0),
    .data_out_D1    (data_out_D1),
    .empty_D0       (empty_D0),
    .empty_D1       (empty_D1),
    .almost_full_D0 (almost_full_D0),
    .almost_full_D1 (almost_full_D1),
    .error_D0       (error_D0),
    .error_D1       (error_D1),
    .active_out     (active_out),
    .idle_out       (idle_out),
    .cnt_D0         (cnt_D0),
    .cnt_D1         (cnt_D1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(input bit rst, input bit ini, input bit pd0, input bit pd1,
                       input logic [2:0] u0, input logic [2:0] u1);
    bit af[2];
    bit pause, run, ep0, ep1, busy, push, pop, was_empty, was_full;
    logic [W-1:0] word;
    @(negedge clk);
    reset = rst; init = ini; pop_D0 = pd0; pop_D1 = pd1;
    Umbral_D0 = u0; Umbral_D1 = u1;
    empty_fifo_VC0 = (vc0q.size() == 0);
    empty_fifo_VC1 = (vc1q.size() == 0);
    data_out_VC0 = vc0_word;
    data_out_VC1 = vc1_word;
    #1;
    for (int d = 0; d < 2; d++) af[d] = !rst && (dq[d].size() >= m_thr[d]);
    pause = af[0] || af[1];
    run   = !rst && !pause && (m_st == MIdle || m_st == MActive);
    ep0   = run && vc0q.size() != 0;
    ep1   = run && vc1q.size() != 0 && !ep0;
    check_eq("pop_vc0", 32'(pop_VC0_fifo), 32'(ep0));
    check_eq("pop_vc1", 32'(pop_VC1_fifo), 32'(ep1));
    check_eq("data_d0", 32'(data_out_D0), 32'(m_dout[0]));
    check_eq("data_d1", 32'(data_out_D1), 32'(m_dout[1]));
    check_eq("empty_d0", 32'(empty_D0), 32'(dq[0].size() == 0));
    check_eq("empty_d1", 32'(empty_D1), 32'(dq[1].size() == 0));
    check_eq("afull_d0", 32'(almost_full_D0), 32'(af[0]));
    check_eq("afull_d1", 32'(almost_full_D1), 32'(af[1]));
    check_eq("err_d0", 32'(error_D0), 32'(m_err[0]));
    check_eq("err_d1", 32'(error_D1), 32'(m_err[1]));
    check_eq("cnt_d0", 32'(cnt_D0), 32'(m_cnt[0]));
    check_eq("cnt_d1", 32'(cnt_D1), 32'(m_cnt[1]));
    check_eq("idle", 32'(idle_out), 32'(m_st == MIdle));
    check_eq("active", 32'(active_out), 32'(m_st == MActive));
    @(posedge clk);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        dq[d].delete();
        m_dout[d] = '0; m_err[d] = 0; m_cnt[d] = 0; m_thr[d] = 0;
      end
      m_pend = 0; m_src = 0; m_st = MReset;
    end else begin
      busy = vc0q.size() != 0 || vc1q.size() != 0 || dq[0].size() != 0 ||
             dq[1].size() != 0 || m_pend;
      word = m_src ? vc1_word : vc0_word;
      for (int d = 0; d < 2; d++) begin
        push      = m_pend && (int'(word[W-1]) == d);
        pop       = (d == 0) ? pd0 : pd1;
        was_empty = (dq[d].size() == 0);
        was_full  = (dq[d].size() == Depth);
        if (pop) begin
          if (was_empty) m_err[d] = 1;
          else           m_dout[d] = dq[d].pop_front();
        end
        if (push) begin
          if (was_full && !pop) m_err[d] = 1;
          else begin
            dq[d].push_back(word);
`ifdef ARB_COUNT_EN
            m_cnt[d] = (m_cnt[d] + 1) % 32;
`endif
          end
        end
      end
      case (m_st)
        MReset: m_st = MInit;
        MInit: begin
          m_thr[0] = int'(u0); m_thr[1] = int'(u1);
          if (!ini) m_st = MIdle;
        end
        MIdle:   m_st = ini ? MInit : (busy ? MActive : MIdle);
        default: m_st = ini ? MInit : (busy ? MActive : MIdle);
      endcase
      m_pend = ep0 || ep1;
      m_src  = ep1;
    end
    if (ep0) vc0_word = vc0q.pop_front();
    if (ep1) vc1_word = vc1q.pop_front();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 3'd3, 3'd3);
  endtask

  task automatic reset_and_init(input logic [2:0] u0, input logic [2:0] u1);
    cycle(1, 0, 0, 0, u0, u1);
    cycle(1, 0, 0, 0, u0, u1);
    cycle(0, 1, 0, 0, u0, u1);
    cycle(0, 1, 0, 0, u0, u1);
    cycle(0, 0, 0, 0, u0, u1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_dout[d] = '0; m_thr[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
    end

    // Reset values while reset is held
    cycle(1, 0, 0, 0, 3'd3, 3'd3);
    cycle(1, 0, 1, 1, 3'd3, 3'd3);
    #1;
    check_eq("rst_data_d0", 32'(data_out_D0), 32'd0);
    check_eq("rst_afull_d0", 32'(almost_full_D0), 32'd0);
    check_eq("rst_err_d0", 32'(error_D0), 32'd0);
    check_eq("rst_idle", 32'(idle_out), 32'd0);
    check_eq("rst_cnt_d0", 32'(cnt_D0), 32'd0);

    // Init with thresholds 3/3, then idle
    cycle(0, 1, 0, 0, 3'd3, 3'd3);
    cycle(0, 1, 0, 0, 3'd3, 3'd3);
    cycle(0, 0, 0, 0, 3'd3, 3'd3);
    #1;
    check_eq("init_idle", 32'(idle_out), 32'd1);
    check_eq("init_active", 32'(active_out), 32'd0);
    check_eq("init_empty_d0", 32'(empty_D0), 32'd1);
    check_eq("init_empty_d1", 32'(empty_D1), 32'd1);
    check_eq("init_afull_d0", 32'(almost_full_D0), 32'd0);

    // VC0 priority; MSB-set word from VC0 lands in D1
    vc0q.push_back(6'b100101);
    vc1q.push_back(6'b000011);
    idle_cycles(4);
    cycle(0, 0, 0, 1, 3'd3, 3'd3);
    #1;
    check_eq("d1_word", 32'(data_out_D1), 32'(6'b100101));

    // Fill D0 to the threshold: pops must pause with VC0 still non-empty
    for (int i = 0; i < 4; i++) vc0q.push_back(6'(8 + i));
    idle_cycles(8);
    #1;
    check_eq("pause_afull_d0", 32'(almost_full_D0), 32'd1);
    check_eq("pause_pop_vc0", 32'(pop_VC0_fifo), 32'd0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 3'd3, 3'd3);
    #1;
    check_eq("underflow_err_d0", 32'(error_D0), 32'd1);
    idle_cycles(5);
    #1;
    check_eq("sticky_err_d0", 32'(error_D0), 32'd1);

    // Overflow: threshold 7 never pauses, so pushes 5 and 6 are dropped
    reset_and_init(3'd7, 3'd7);
    #1;
    check_eq("clean_err_d0", 32'(error_D0), 32'd0);
    for (int i = 0; i < 6; i++) vc0q.push_back(6'(16 + i));
    idle_cycles(12);
    #1;
    check_eq("overflow_err_d0", 32'(error_D0), 32'd1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 3'd7, 3'd7);
    #1;
    check_eq("overflow_last_kept", 32'(data_out_D0), 32'd19);

    // Randomised traffic with occasional re-init and reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) vc0q.push_back(W'($urandom));
      if ($urandom_range(0, 3) == 0) vc1q.push_back(W'($urandom));
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // 33 accepted pushes to D0 wrap the counter to 1
    vc0q.delete();
    vc1q.delete();
    reset_and_init(3'd7, 3'd7);
    for (int i = 0; i < 33; i++) vc0q.push_back(6'(i % 32));
    for (int i = 0; i < 45; i++) cycle(0, 0, 1, 0, 3'd7, 3'd7);
    #1;
`ifdef ARB_COUNT_EN
    check_eq("cnt_wrap_d0", 32'(cnt_D0), 32'd1);
`else
    check_eq("cnt_tied_d0", 32'(cnt_D0), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
